// File: rtl/dsp_mul_share_arbiter_pkg.sv
// rtl/dsp_mul_share_arbiter_pkg.sv - shared widths, id-width helper and tagged request/result types
package dsp_mul_arb_pkg;

    localparam int A_W         = 20;
    localparam int B_W         = 18;
    localparam int P_W         = A_W + B_W;
    localparam int NUM_REQ_MAX = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tags are sized for the largest supported requester count; the top trims them.
    localparam int ID_W = id_w(NUM_REQ_MAX);

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
        logic [ID_W-1:0]       id;
    } mul_req_t;

    typedef struct packed {
        logic signed [P_W-1:0] p;
        logic signed [B_W-1:0] b;
        logic [ID_W-1:0]       id;
    } mul_res_t;

endpackage

// File: rtl/dsp_mul_share_arbiter_if.sv
// rtl/dsp_mul_share_arbiter_if.sv - requester and result handshake bundle for the shared multiplier
interface dsp_mul_share_arbiter_if
    import dsp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic signed [P_W-1:0]  res_p;
    logic [IDW-1:0]         res_id;
    logic signed [B_W-1:0]  res_b;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id, res_b
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id, res_b
    );

endinterface

// File: rtl/dsp_mul_share_arbiter_mul.sv
// rtl/dsp_mul_share_arbiter_mul.sv - LAT-stage signed multiplier carrying valid and tag sideband
module dsp_mul_pipe
    import dsp_mul_arb_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid_i,
    input  mul_req_t in_req_i,
    output logic     out_valid_o,
    output mul_res_t out_res_o
);
    logic [LAT-1:0]        valid_q;
    mul_res_t              res_q [LAT];
    logic signed [P_W-1:0] prod;

    assign prod = $signed({{B_W{in_req_i.a[A_W-1]}}, in_req_i.a})
                * $signed({{A_W{in_req_i.b[B_W-1]}}, in_req_i.b});

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data stages need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        res_q[0] <= '{p: prod, b: in_req_i.b, id: in_req_i.id};
        for (int i = 1; i < LAT; i++) begin
            res_q[i] <= res_q[i-1];
        end
    end

    assign out_valid_o = valid_q[LAT-1];
    assign out_res_o   = res_q[LAT-1];

endmodule

// File: rtl/dsp_mul_share_arbiter.sv
// rtl/dsp_mul_share_arbiter.sv - credit-guarded arbiter, shared multiplier and result FIFO
// Define DSP_MUL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module dsp_mul_share_arbiter
    import dsp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dsp_mul_share_arbiter_if.slave bus
);
    localparam int IDW  = id_w(NUM_REQ);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               arb_found;
    logic               accept;
    mul_req_t           issue_req;
    logic               pipe_valid;
    mul_res_t           pipe_res;
    logic [CW-1:0]      credits_q, credits_d;
    mul_res_t           mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               fifo_valid;
    logic               pop;
    mul_res_t           head;
    logic               unused_head_id;

`ifdef DSP_MUL_ARB_RR_EN
    logic [IDW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            ptr_q <= grant_idx;
        end
    end

    // Walk ptr+1 .. ptr+NUM_REQ on a doubled ring so the indices stay loop constants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        arb_found = 1'b0;
        if (!reset && credits_q != '0) begin
            for (int i = 1; i < 2 * NUM_REQ; i++) begin
                if (!arb_found && i > int'(ptr_q) && i <= int'(ptr_q) + NUM_REQ
                    && bus.req_valid[i % NUM_REQ]) begin
                    arb_found              = 1'b1;
                    grant[i % NUM_REQ]     = 1'b1;
                    grant_idx              = IDW'(i % NUM_REQ);
                end
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        arb_found = 1'b0;
        if (!reset && credits_q != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb_found && bus.req_valid[i]) begin
                    arb_found = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end
`endif

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign issue_req     = '{a:  bus.req_a[grant_idx*A_W +: A_W],
                             b:  bus.req_b[grant_idx*B_W +: B_W],
                             id: ID_W'(grant_idx)};

    dsp_mul_pipe #(.LAT(LAT)) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (accept),
        .in_req_i   (issue_req),
        .out_valid_o(pipe_valid),
        .out_res_o  (pipe_res)
    );

    // A credit covers one FIFO slot from accept until that product is popped.
    always_comb begin
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !accept) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (pipe_valid && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !pipe_valid) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q <= CW'(FIFO_DEPTH);
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            if (pipe_valid) begin
                wr_ptr_q <= (wr_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pipe_valid) begin
            mem_q[wr_ptr_q] <= pipe_res;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign fifo_valid     = (count_q != '0);
    assign pop            = fifo_valid && bus.res_ready;
    assign unused_head_id = ^head.id;

    assign bus.res_valid = fifo_valid;
    assign bus.res_p     = fifo_valid ? head.p : '0;
    assign bus.res_b     = fifo_valid ? head.b : '0;
    assign bus.res_id    = fifo_valid ? head.id[IDW-1:0] : '0;

endmodule

// File: tb/tb_dsp_mul_share_arbiter.sv
// tb/tb_dsp_mul_share_arbiter.sv - directed vectors plus scoreboard for dsp_mul_share_arbiter
module tb_dsp_mul_share_arbiter;
    import dsp_mul_arb_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    typedef struct {
        int     id;
        longint a;
        longint b;
        longint p;
    } vec_t;

    typedef struct {
        longint p;
        longint b;
        int     id;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_mul_share_arbiter_if #(.NUM_REQ(N)) bus ();

    dsp_mul_share_arbiter #(.NUM_REQ(N), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   sb_q[$];
    int     acc_ids[$];
    exp_t   mon_e;
    longint mon_a;
    longint mon_b;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input longint a, input longint b);
        bus.req_a[id*A_W +: A_W] = A_W'(a);
        bus.req_b[id*B_W +: B_W] = B_W'(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            checks++;
            if (!$onehot0(bus.req_ready) || (bus.req_ready & ~bus.req_valid) != '0) begin
                errors++;
                $display("FAIL grant_legal: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id %0d p %0d expected nothing", bus.res_id, bus.res_p);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_p", bus.res_p, mon_e.p);
                    check("sb_id", longint'(bus.res_id), longint'(mon_e.id));
                    check("sb_b", bus.res_b, mon_e.b);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    mon_a = $signed(bus.req_a[i*A_W +: A_W]);
                    mon_b = $signed(bus.req_b[i*B_W +: B_W]);
                    sb_q.push_back('{p: mon_a * mon_b, b: mon_b, id: i});
                    acc_ids.push_back(i);
                end
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   seen;
        int   exp_id;

        vecs[0] = '{0, 5, 2, 10};
        vecs[1] = '{1, -3, 7, -21};
        vecs[2] = '{2, -524288, -131072, 64'sd68719476736};
        vecs[3] = '{3, 524287, 131071, 64'sd68718821377};
        vecs[4] = '{3, -524288, 131071, -64'sd68718952448};
        vecs[5] = '{1, 1, -1, -1};

        reset         = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", longint'(bus.req_ready), 0);
        check("rst_res_valid", longint'(bus.res_valid), 0);
        check("rst_res_p", bus.res_p, 0);
        check("rst_res_id", longint'(bus.res_id), 0);
        check("rst_res_b", bus.res_b, 0);
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            bus.req_valid = N'(1) << vecs[v].id;
            #1;
            check($sformatf("vec%0d_ready", v), longint'(bus.req_ready), longint'(1) << vecs[v].id);
            tick();
            bus.req_valid = '0;
            for (int s = 1; s < LAT; s++) begin
                check($sformatf("vec%0d_early", v), longint'(bus.res_valid), 0);
                tick();
            end
            check($sformatf("vec%0d_early", v), longint'(bus.res_valid), 0);
            tick();
            check($sformatf("vec%0d_valid", v), longint'(bus.res_valid), 1);
            check($sformatf("vec%0d_p", v), bus.res_p, vecs[v].p);
            check($sformatf("vec%0d_id", v), longint'(bus.res_id), longint'(vecs[v].id));
            check($sformatf("vec%0d_b", v), bus.res_b, vecs[v].b);
            tick();
        end

        do_reset();
        acc_ids.delete();
        for (int i = 0; i < N; i++) set_req(i, 100 + i, -3 * (i + 1));
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        repeat (8) tick();
        bus.req_valid = '0;
        repeat (10) tick();
        check("fair_count", acc_ids.size(), 8);
        for (int k = 0; k < 8; k++) begin
`ifdef DSP_MUL_ARB_RR_EN
            exp_id = k % N;
`else
            exp_id = 0;
`endif
            if (k < acc_ids.size()) check($sformatf("fair_id%0d", k), acc_ids[k], exp_id);
        end
        check("fair_drain", sb_q.size(), 0);

        do_reset();
        acc_ids.delete();
        bus.res_ready = 1'b0;
        bus.req_valid = '1;
        repeat (10) tick();
        check("bp_accepts", acc_ids.size(), DEPTH);
        check("bp_ready_low", longint'(bus.req_ready), 0);
        check("bp_res_valid", longint'(bus.res_valid), 1);
        bus.res_ready = 1'b1;
        #1;
        check("bp_ready_indep", longint'(bus.req_ready), 0);
        tick();
        check("bp_resume", longint'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        repeat (12) tick();
        check("bp_total", acc_ids.size(), DEPTH + 1);
        check("bp_drain", sb_q.size(), 0);

        do_reset();
        acc_ids.delete();
        bus.res_ready = 1'b0;
        set_req(0, 7, 9);
        bus.req_valid = N'(1);
        repeat (3) tick();
        bus.req_valid = '0;
        tick();
        check("mf_accepts", acc_ids.size(), 3);
        check("mf_buffered", longint'(bus.res_valid), 1);
        reset         = 1'b1;
        bus.req_valid = '1;
        #1;
        check("mf_ready_in_reset", longint'(bus.req_ready), 0);
        tick();
        tick();
        check("mf_res_valid", longint'(bus.res_valid), 0);
        check("mf_res_p", bus.res_p, 0);
        check("mf_res_id", longint'(bus.res_id), 0);
        check("mf_res_b", bus.res_b, 0);
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (bus.res_valid) seen++;
        end
        check("mf_no_emit", seen, 0);
        set_req(2, -11, 13);
        bus.req_valid = N'(4);
        tick();
        bus.req_valid = '0;
        repeat (LAT) tick();
        check("mf_new_valid", longint'(bus.res_valid), 1);
        check("mf_new_p", bus.res_p, -143);
        check("mf_new_id", longint'(bus.res_id), 2);
        tick();
        check("mf_drain", sb_q.size(), 0);

        do_reset();
        acc_ids.delete();
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) set_req(i, $random, $random);
            bus.req_valid = N'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (12) tick();
        check("soak_active", longint'(acc_ids.size() > 200), 1);
        check("soak_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
